multicycle_control_fsm: RTL

- Parametrised multicycle successor to the single-cycle RV32I main decoder.
- Moore control FSM plus combinational ImmSrc/ALUOp decode. Sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds a memory-ready handshake, optional jal/bne support, illegal-opcode trapping and a retire pulse.
- Sits between the instruction register (op/funct3) and the shared-memory multicycle datapath.

---
 rtl/multicycle_control_fsm.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: Moore control FSM for the shared-memory multicycle RV32I datapath.
// Rev 1.0 - fetch/decode/execute/memory/writeback sequencing with mem_ready stalls and trapping.
`default_nettype none

module multicycle_control_fsm #(
  parameter int USE_MEM_READY = 1,
  parameter int JAL_EN        = 1,
  parameter int BNE_EN        = 1,
  parameter int TRAP_STICKY   = 0,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               AdrSrc,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ALUOp,
  output logic [1:0]         ImmSrc,
  output logic               illegal,
  output logic               instr_retired,
  output logic [STATE_W-1:0] state
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_NOP = 7'b0000000;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECUTEI = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  // Per-state control fields; the handshake-dependent ones are qualified at the outputs.
  typedef struct packed {
    logic       fetch;
    logic       decode;
    logic       pcupdate;
    logic       adrsrc;
    logic       memwrite;
    logic       regwrite;
    logic       branch;
    logic       retire;
    logic       retire_rdy;
    logic       illegal;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
  } ctrl_t;

  function automatic ctrl_t ctrl_for(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.fetch     = 1'b1;
        c.alusrcb   = 2'b10;
        c.resultsrc = 2'b10;
      end
      S_DECODE: begin
        c.decode  = 1'b1;
        c.alusrca = 2'b01;
        c.alusrcb = 2'b01;
      end
      S_MEMADR: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        c.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        c.resultsrc = 2'b01;
        c.regwrite  = 1'b1;
        c.retire    = 1'b1;
      end
      S_MEMWRITE: begin
        c.adrsrc     = 1'b1;
        c.memwrite   = 1'b1;
        c.retire_rdy = 1'b1;
      end
      S_EXECUTER: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b10;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.retire   = 1'b1;
      end
      S_EXECUTEI: begin
        c.alusrca = 2'b10;
        c.alusrcb = 2'b01;
        c.aluop   = 2'b10;
      end
      S_JAL: begin
        c.alusrca  = 2'b01;
        c.alusrcb  = 2'b10;
        c.pcupdate = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 2'b10;
        c.aluop   = 2'b01;
        c.branch  = 1'b1;
        c.retire  = 1'b1;
      end
      S_ILLEGAL: begin
        c.illegal = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_t st;
  state_t st_nxt;
  ctrl_t  ctrl;
  logic   ready;
  logic   br_legal;
  logic   take;

  assign ready    = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
  assign br_legal = (funct3 == 3'b000) || ((BNE_EN != 0) && (funct3 == 3'b001));
  assign take     = (funct3 == 3'b001) ? ~zero : zero;

  always_comb begin
    st_nxt = S_FETCH;
    case (st)
      S_FETCH:    st_nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: st_nxt = S_MEMADR;
          OP_R:         st_nxt = S_EXECUTER;
          OP_I:         st_nxt = S_EXECUTEI;
          OP_BR:        st_nxt = br_legal ? S_BRANCH : S_ILLEGAL;
          OP_JAL:       st_nxt = (JAL_EN != 0) ? S_JAL : S_ILLEGAL;
          OP_NOP:       st_nxt = S_FETCH;
          default:      st_nxt = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   st_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  st_nxt = ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    st_nxt = S_FETCH;
      S_MEMWRITE: st_nxt = ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: st_nxt = S_ALUWB;
      S_EXECUTEI: st_nxt = S_ALUWB;
      S_ALUWB:    st_nxt = S_FETCH;
      S_JAL:      st_nxt = S_ALUWB;
      S_BRANCH:   st_nxt = S_FETCH;
      S_ILLEGAL:  st_nxt = (TRAP_STICKY != 0) ? S_ILLEGAL : S_FETCH;
      default:    st_nxt = S_FETCH;
    endcase
  end

  // Control fields are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      st   <= S_FETCH;
      ctrl <= ctrl_for(S_FETCH);
    end else begin
      st   <= st_nxt;
      ctrl <= ctrl_for(st_nxt);
    end
  end

  assign IRWrite       = ctrl.fetch & ready & ~reset;
  assign PCWrite       = ((ctrl.fetch & ready) | ctrl.pcupdate | (ctrl.branch & take)) & ~reset;
  assign MemWrite      = ctrl.memwrite & ~reset;
  assign RegWrite      = ctrl.regwrite & ~reset;
  assign AdrSrc        = ctrl.adrsrc;
  assign ResultSrc     = ctrl.resultsrc;
  assign ALUSrcA       = ctrl.alusrca;
  assign ALUSrcB       = ctrl.alusrcb;
  assign ALUOp         = ctrl.aluop;
  assign illegal       = ctrl.illegal;
  assign instr_retired = ctrl.retire | (ctrl.retire_rdy & ready) | (ctrl.decode & (op == OP_NOP));
  assign state         = STATE_W'(st);

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BR:   ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

endmodule

`default_nettype wire
